// File: rtl/measure_unit_pkg.sv
// rtl/measure_unit_pkg.sv - shared types and constants for the measure unit
//
// Purpose: state encoding and error codes for the threshold SAR controller,
//          plus the DAC code width shared across measure_unit.
package measure_unit_pkg;

  localparam int DAC_CODE_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DAC_WR,
    ST_DAC_WAIT,
    ST_SETTLE,
    ST_STB_REQ,
    ST_DECIDE,
    ST_DONE,
    ST_ERR
  } sar_state_t;

  localparam logic [1:0] SAR_ERR_NONE = 2'b00;
  localparam logic [1:0] SAR_ERR_DAC  = 2'b01;
  localparam logic [1:0] SAR_ERR_STB  = 2'b10;

endpackage

// File: rtl/sar_vote_cnt.sv
// rtl/sar_vote_cnt.sv - sample/ones counter with majority decision
//
// Purpose: counts comparator samples of one strobe group and reports the
//          majority result for the bit under test.
// Ports:
//   clk_i    in   controller clock
//   arstn_i  in   asynchronous active-low reset
//   clr_i    in   synchronous clear of both counters
//   valid_i  in   accepted comparator sample this cycle
//   bit_i    in   comparator value of that sample
//   done_o   out  high with the sample that completes the group
//   maj_o    out  more than half of the counted samples were ones
module sar_vote_cnt #(
  parameter int SAMPLES = 7
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic bit_i,
  output logic done_o,
  output logic maj_o
);

  localparam int SW = $clog2(SAMPLES + 1);

  logic [SW-1:0] r_samples;
  logic [SW-1:0] r_ones;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (clr_i) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (valid_i) begin
      r_samples <= r_samples + SW'(1);
      r_ones    <= r_ones + SW'(bit_i);
    end
  end

  // Done is flagged combinationally with the last sample so the controller
  // can drop its strobe request in the cycle the count reaches SAMPLES.
  assign done_o = valid_i && (r_samples == SW'(SAMPLES - 1));

  // 2*ones > SAMPLES, one extra bit so the doubled count cannot overflow.
  assign maj_o = ({1'b0, r_ones} << 1) > (SW + 1)'(SAMPLES);

endmodule

// File: rtl/threshold_sar_ctl.sv
// rtl/threshold_sar_ctl.sv - successive-approximation comparator threshold search
//
// Purpose: resolves the DAC code at which the comparator switches, MSB first,
//          deciding each bit by majority vote over SAMPLES strobes.
// Ports:
//   clk_i        in   controller clock
//   arstn_i      in   asynchronous active-low reset
//   run_i        in   level: high starts/holds a search, low aborts/clears
//   cmp_i        in   comparator output, synchronous to clk_i
//   dac_code_o   out  code presented to the SPI master
//   dac_wre_o    out  one-cycle write pulse to the SPI master
//   dac_rdy_i    in   SPI master idle/done
//   stb_req_o    out  strobe request level
//   stb_valid_i  in   strobe issued, cmp_i valid this cycle
//   res_o        out  resolved threshold code
//   busy_o       out  search in progress
//   rdy_o        out  res_o valid
//   err_o        out  00 none, 01 DAC timeout, 10 strobe timeout
module threshold_sar_ctl
  import measure_unit_pkg::*;
#(
  parameter int CODE_WIDTH     = DAC_CODE_WIDTH,
  parameter int SETTLE_CYCLES  = 32,
  parameter int SAMPLES        = 7,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  run_i,
  input  logic                  cmp_i,
  output logic [CODE_WIDTH-1:0] dac_code_o,
  output logic                  dac_wre_o,
  input  logic                  dac_rdy_i,
  output logic                  stb_req_o,
  input  logic                  stb_valid_i,
  output logic [CODE_WIDTH-1:0] res_o,
  output logic                  busy_o,
  output logic                  rdy_o,
  output logic [1:0]            err_o
);

  localparam int BW  = $clog2(CODE_WIDTH);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);

  sar_state_t            r_state;
  logic [BW-1:0]         r_bit;
  logic [CODE_WIDTH-1:0] r_trial;
  logic [TW-1:0]         r_tmo;
  logic [STW-1:0]        r_settle;
  logic [CODE_WIDTH-1:0] r_dac_code;
  logic                  r_dac_wre;
  logic                  r_stb_req;
  logic [CODE_WIDTH-1:0] r_res;
  logic                  r_busy;
  logic                  r_rdy;
  logic [1:0]            r_err;

  logic                  w_busy_state;
  logic                  w_sample;
  logic                  w_vote_clr;
  logic                  w_done;
  logic                  w_maj;
  logic [CODE_WIDTH-1:0] w_bit_mask;
  logic [CODE_WIDTH-1:0] w_next_mask;
  logic [CODE_WIDTH-1:0] w_trial_next;

  assign w_busy_state = (r_state == ST_DAC_WR)  || (r_state == ST_DAC_WAIT) ||
                        (r_state == ST_SETTLE)  || (r_state == ST_STB_REQ)  ||
                        (r_state == ST_DECIDE);

  // A strobe coinciding with run_i falling is dropped: the abort wins.
  assign w_sample   = (r_state == ST_STB_REQ) && stb_valid_i && run_i;
  assign w_vote_clr = (r_state == ST_SETTLE);

  assign w_bit_mask   = CODE_WIDTH'(1) << r_bit;
  assign w_next_mask  = CODE_WIDTH'(1) << (r_bit - BW'(1));
  assign w_trial_next = w_maj ? (r_trial | w_bit_mask) : r_trial;

  sar_vote_cnt #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .clr_i   (w_vote_clr),
    .valid_i (w_sample),
    .bit_i   (cmp_i),
    .done_o  (w_done),
    .maj_o   (w_maj)
  );

  // Outputs are registered: dac_wre_o / stb_req_o are set on the transition
  // into the state they belong to, so they line up exactly with that state.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= ST_IDLE;
      r_bit      <= '0;
      r_trial    <= '0;
      r_tmo      <= '0;
      r_settle   <= '0;
      r_dac_code <= '0;
      r_dac_wre  <= 1'b0;
      r_stb_req  <= 1'b0;
      r_res      <= '0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      r_err      <= SAR_ERR_NONE;
    end else begin
      r_dac_wre <= 1'b0;
      if (w_busy_state && !run_i) begin
        r_state   <= ST_IDLE;
        r_stb_req <= 1'b0;
        r_busy    <= 1'b0;
        r_rdy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run_i && dac_rdy_i) begin
              r_state    <= ST_DAC_WR;
              r_bit      <= BW'(CODE_WIDTH - 1);
              r_trial    <= '0;
              r_res      <= '0;
              r_rdy      <= 1'b0;
              r_busy     <= 1'b1;
              r_dac_wre  <= 1'b1;
              r_dac_code <= CODE_WIDTH'(1) << (CODE_WIDTH - 1);
            end
          end
          ST_DAC_WR: begin
            r_state <= ST_DAC_WAIT;
            r_tmo   <= '0;
          end
          ST_DAC_WAIT: begin
            // r_tmo is zero only in the first cycle, covering the SPI
            // master's delay before it drops dac_rdy_i.
            if ((r_tmo != '0) && dac_rdy_i) begin
              r_state  <= ST_SETTLE;
              r_settle <= '0;
            end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
              r_state <= ST_ERR;
              r_err   <= SAR_ERR_DAC;
              r_busy  <= 1'b0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          ST_SETTLE: begin
            if (r_settle == STW'(SETTLE_CYCLES - 1)) begin
              r_state   <= ST_STB_REQ;
              r_stb_req <= 1'b1;
              r_tmo     <= '0;
            end else begin
              r_settle <= r_settle + STW'(1);
            end
          end
          ST_STB_REQ: begin
            if (w_done) begin
              r_state   <= ST_DECIDE;
              r_stb_req <= 1'b0;
            end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
              r_state   <= ST_ERR;
              r_err     <= SAR_ERR_STB;
              r_stb_req <= 1'b0;
              r_busy    <= 1'b0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          ST_DECIDE: begin
            r_trial <= w_trial_next;
            if (r_bit == '0) begin
              r_state <= ST_DONE;
              r_res   <= w_trial_next;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= ST_DAC_WR;
              r_bit      <= r_bit - BW'(1);
              r_dac_wre  <= 1'b1;
              r_dac_code <= w_trial_next | w_next_mask;
            end
          end
          ST_DONE: begin
            if (!run_i) begin
              r_state <= ST_IDLE;
            end
          end
          ST_ERR: begin
            if (!run_i) begin
              r_state <= ST_IDLE;
              r_err   <= SAR_ERR_NONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dac_code_o = r_dac_code;
  assign dac_wre_o  = r_dac_wre;
  assign stb_req_o  = r_stb_req;
  assign res_o      = r_res;
  assign busy_o     = r_busy;
  assign rdy_o      = r_rdy;
  assign err_o      = r_err;

endmodule

// File: tb/tb_threshold_sar_ctl.sv
// tb/tb_threshold_sar_ctl.sv - scoreboard bench for threshold_sar_ctl
module tb_threshold_sar_ctl;

  localparam int CW     = 16;
  localparam int SETTLE = 4;
  localparam int NS     = 7;
  localparam int TMO    = 64;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          run_i;
  logic          cmp_i;
  logic [CW-1:0] dac_code_o;
  logic          dac_wre_o;
  logic          dac_rdy_i;
  logic          stb_req_o;
  logic          stb_valid_i;
  logic [CW-1:0] res_o;
  logic          busy_o;
  logic          rdy_o;
  logic [1:0]    err_o;

  threshold_sar_ctl #(
    .CODE_WIDTH     (CW),
    .SETTLE_CYCLES  (SETTLE),
    .SAMPLES        (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .run_i       (run_i),
    .cmp_i       (cmp_i),
    .dac_code_o  (dac_code_o),
    .dac_wre_o   (dac_wre_o),
    .dac_rdy_i   (dac_rdy_i),
    .stb_req_o   (stb_req_o),
    .stb_valid_i (stb_valid_i),
    .res_o       (res_o),
    .busy_o      (busy_o),
    .rdy_o       (rdy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] exp_q[$];

  // Environment knobs.
  // mode: 0 clean threshold, 1 noisy threshold, 2 always one, 3 always zero
  int            mode = 0;
  logic [CW-1:0] thr = '0;
  int            spi_delay = 10;
  int            stb_interval = 8;
  bit            hold_dac = 0;
  bit            no_strobe = 0;
  int            wre_cnt = 0;
  logic [CW-1:0] first_code = '0;
  bit            saw_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Comparator: true when the applied code does not exceed the threshold.
  // In noisy mode each group of 7 strobes yields 4 ones / 3 zeros when the
  // true answer is 1 and 3 ones / 4 zeros when it is 0.
  function automatic logic env_cmp(input logic [CW-1:0] code, input int k);
    logic truth;
    case (mode)
      0, 1:    truth = (code <= thr);
      2:       truth = 1'b1;
      default: truth = 1'b0;
    endcase
    if (mode == 1) return truth ? (k < 4) : (k < 3);
    return truth;
  endfunction

  // Reference: the search yields the largest code the comparator accepts,
  // or zero when it accepts none.
  function automatic logic [CW-1:0] ref_result(input int m, input logic [CW-1:0] t);
    case (m)
      2:       return {CW{1'b1}};
      3:       return '0;
      default: return t;
    endcase
  endfunction

  // SPI master model: rdy drops after a write and returns spi_delay cycles later.
  initial begin
    int spi_left;
    spi_left  = 0;
    dac_rdy_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (dac_wre_o) begin
        if (wre_cnt == 0) first_code = dac_code_o;
        wre_cnt++;
        dac_rdy_i = 1'b0;
        spi_left  = spi_delay;
      end else if (!dac_rdy_i && !hold_dac) begin
        if (spi_left <= 1) dac_rdy_i = 1'b1;
        else spi_left--;
      end
    end
  end

  // Strobe generator model: one valid pulse every stb_interval cycles of request.
  initial begin
    int stb_cnt;
    int grp_idx;
    stb_cnt     = 0;
    grp_idx     = 0;
    stb_valid_i = 1'b0;
    cmp_i       = 1'b0;
    forever begin
      @(negedge clk_i);
      stb_valid_i = 1'b0;
      if (stb_req_o) saw_req = 1;
      if (stb_req_o && !no_strobe) begin
        stb_cnt++;
        if (stb_cnt >= stb_interval) begin
          stb_cnt     = 0;
          stb_valid_i = 1'b1;
          cmp_i       = env_cmp(dac_code_o, grp_idx);
          grp_idx++;
        end
      end else begin
        stb_cnt = 0;
        grp_idx = 0;
      end
    end
  end

  // Monitor: every rising rdy_o consumes one expected result.
  initial begin
    logic          prev;
    logic [CW-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rdy_o && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 32'(rdy_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_o", 32'(res_o), 32'(e));
          check("busy_at_done", 32'(busy_o), 32'd0);
        end
      end
      prev = rdy_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic search(input int m, input logic [CW-1:0] t, input int dly, input int ivl);
    int n;
    mode         = m;
    thr          = t;
    spi_delay    = dly;
    stb_interval = ivl;
    wre_cnt      = 0;
    exp_q.push_back(ref_result(m, t));
    run_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rdy_o && err_o == 2'b00 && n < 20000);
    check("search_done", 32'(rdy_o), 32'd1);
    check("search_err", 32'(err_o), 32'd0);
    check("wre_pulses", 32'(wre_cnt), 32'd16);
    check("first_code", 32'(first_code), 32'h8000);
    run_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    int  n;
    int  my_wre;
    logic prev_req;

    arstn_i = 1'b0;
    run_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_dac_code", 32'(dac_code_o), 32'd0);
    check("rst_wre", 32'(dac_wre_o), 32'd0);
    check("rst_stb_req", 32'(stb_req_o), 32'd0);
    check("rst_res", 32'(res_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rdy", 32'(rdy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    search(0, 16'h1234, 10, 8);
    search(2, 16'h0000, 10, 8);
    search(3, 16'h0000, 10, 8);
    search(1, 16'h00FF, 10, 8);
    for (int i = 0; i < 4; i++) begin
      search(0, CW'($urandom), int'($urandom_range(2, 12)), int'($urandom_range(2, 8)));
    end
    search(1, CW'($urandom), int'($urandom_range(2, 12)), int'($urandom_range(2, 8)));

    // DAC timeout: SPI master never returns ready after the first write.
    hold_dac = 1;
    saw_req  = 0;
    run_i    = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!dac_wre_o && n < 100);
    check("dac_tmo_wre_seen", 32'(dac_wre_o), 32'd1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (err_o == 2'b00 && n < 300);
    check("dac_tmo_cycles", 32'(n), 32'd65);
    check("dac_tmo_err", 32'(err_o), 32'd1);
    check("dac_tmo_busy", 32'(busy_o), 32'd0);
    check("dac_tmo_no_req", 32'(saw_req), 32'd0);
    run_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("dac_tmo_clear", 32'(err_o), 32'd0);
    hold_dac = 0;
    repeat (20) @(negedge clk_i);

    // Strobe timeout: request is never answered.
    no_strobe    = 1;
    spi_delay    = 5;
    run_i        = 1'b1;
    prev_req     = 1'b0;
    n = 0;
    while (err_o == 2'b00 && n < 2000) begin
      prev_req = stb_req_o;
      @(negedge clk_i);
      n++;
    end
    check("stb_tmo_err", 32'(err_o), 32'd2);
    check("stb_tmo_req_drop", 32'(stb_req_o), 32'd0);
    check("stb_tmo_req_before", 32'(prev_req), 32'd1);
    check("stb_tmo_busy", 32'(busy_o), 32'd0);
    run_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("stb_tmo_clear", 32'(err_o), 32'd0);
    no_strobe = 0;
    repeat (5) @(negedge clk_i);

    // Abort while strobing bit 9 (seventh write of the search).
    mode         = 0;
    thr          = CW'($urandom);
    spi_delay    = 6;
    stb_interval = 5;
    my_wre       = 0;
    run_i        = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      if (dac_wre_o) my_wre++;
      n++;
    end while (!(my_wre == 7 && stb_req_o) && n < 5000);
    check("abort_reached_bit9", 32'(stb_req_o), 32'd1);
    run_i = 1'b0;
    @(negedge clk_i);
    check("abort_stb_req", 32'(stb_req_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_rdy", 32'(rdy_o), 32'd0);
    check("abort_res", 32'(res_o), 32'd0);
    repeat (3) @(negedge clk_i);
    search(0, CW'($urandom), 7, 4);

    // Reset in the middle of a search returns everything to zero at once.
    mode  = 0;
    thr   = 16'h4321;
    run_i = 1'b1;
    repeat (150) @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_dac_code", 32'(dac_code_o), 32'd0);
    check("midrst_stb_req", 32'(stb_req_o), 32'd0);
    check("midrst_res", 32'(res_o), 32'd0);
    run_i = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (20) @(negedge clk_i);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
